mem_stage_split: RTL and testbench
==================================

# mem_stage_split

Parametrised MEM pipeline stage for the five-stage MIPS core. It sits between EX and WB and receives load data from a split-transaction data SRAM interface with variable latency (`data_ok` handshake), not a fixed one-cycle SRAM. It buffers an early response while WB stalls and discards responses that belong to flushed loads. Its load-alignment unit covers LW/LH/LHU/LB/LBU and, optionally, LWL/LWR. It also drives the forwarding and load-use stall information used by ID.

## Interface
- `CANCEL_W`, 2: width of the discard counter; the maximum count is 2^CANCEL_W-1.
- `clk` in 1: clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `es_to_ms_valid` in 1: EX holds a valid instruction.
- `ms_allowin` out 1: MS accepts an instruction this cycle.
- `es_pc` in 32: instruction PC.
- `es_alu_result` in 32: ALU result, or load address.
- `es_dest` in 5: destination GPR.
- `es_gr_we` in 1: GPR write enable.
- `es_rt_value` in 32: old rt value, used for the LWL/LWR merge.
- `es_ld_op` in 3: load type. 0 none, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 LWL, 7 LWR.
- `es_mem_req` in 1: EX issued a data request that will return exactly one `data_ok`. Stores set it too.
- `flush` in 1: kill MS contents and any incoming instruction this cycle.
- `data_sram_data_ok` in 1: one response beat. Responses return in request order.
- `data_sram_rdata` in 32: response data, valid when `data_ok` is high.
- `ws_allowin` in 1: WB accepts.
- `ms_to_ws_valid` out 1: MS result valid toward WB.
- `ms_pc` out 32: PC passed to WB.
- `ms_dest` out 5: destination GPR passed to WB.
- `ms_gr_we` out 1: write enable passed to WB. It is 0 whenever `ms_to_ws_valid` is 0.
- `ms_final_result` out 32: write-back value.
- `ms_fwd_valid` out 1: `ms_valid & ms_gr_we`.
- `ms_fwd_dest` out 5: destination for forwarding.
- `ms_fwd_data` out 32: equal to `ms_final_result`.
- `ms_fwd_stall` out 1: MS holds a load whose data is not yet available. ID must stall on a match.

## Operation
- State is `EMPTY`, `WAIT`, `READY`, plus `cancel_cnt`.
- **Entry.** An instruction enters on `es_to_ms_valid & ms_allowin & ~flush`. It enters `WAIT` if `es_mem_req` is set, otherwise `READY`.
- **WAIT.** A `data_ok` while `cancel_cnt==0` captures `rdata` into `rbuf` and moves the stage to `READY`.
  - If `ws_allowin` is also high that cycle, the result passes to WB combinationally from `rdata`.
  - A new entry may be accepted in the same cycle.
- **READY.** The result is taken from `rbuf` for loads or from `alu_result` otherwise. The stage leaves on `ws_allowin`.
- **Ready and allowin.** `ms_ready_go = READY | (WAIT & data_ok & cancel_cnt==0)`. `ms_allowin = (EMPTY | ms_ready_go & ws_allowin) & (cancel_cnt != max)`.
- **Load alignment** uses `a = alu_result[1:0]`.
  - LH/LHU select the halfword by `a[1]`, sign- or zero-extended.
  - LB/LBU select byte `a`.
  - LW passes the word through.
  - Loads with `es_ld_op==0` (stores) still wait for `data_ok`. Their result is `alu_result` with `gr_we` as supplied.
- **Flush.** The stage goes to `EMPTY` next cycle and nothing enters. `cancel_cnt` is adjusted as follows:
  - +1 if MS is in `WAIT` and no matching `data_ok` arrives this cycle.
  - +1 if `es_to_ms_valid & es_mem_req`.
  - −1 if `data_ok` arrives with `cancel_cnt>0`.
  - All adjustments apply in the same cycle.
- **Discard.** Any `data_ok` while `cancel_cnt>0` is discarded and decrements the counter. Discards are in order, so they precede the response of a newer load.

## Timing
- **Reset.** `ms_valid=0`, state `EMPTY`, `cancel_cnt=0`, `rbuf=0`, `ms_allowin=1`, `ms_to_ws_valid=0`, `ms_fwd_valid=0`, `ms_fwd_stall=0`. The pc/dest/result outputs are 0.
- **Non-memory instruction.** `ms_to_ws_valid` goes high the cycle after entry.
- **Load.** The earliest `data_ok` is the first MS cycle. Latency is 1 cycle plus response delay.
- **Stall.** `ms_fwd_stall` is high in every `WAIT` cycle except one where a usable `data_ok` arrives.
- **Saturated counter.** With `cancel_cnt` at its maximum, `ms_allowin` is held at 0 until a discard occurs.
- **Reset mid-load.** The counter is cleared. The system guarantees no response is outstanding across reset.

## Configuration
- `MS_UNALIGNED_LOAD_EN` defined: LWL/LWR merge `rdata` with `rt_value`.
  - LWL, by `a` = 0/1/2/3: `{rd[7:0],rt[23:0]}`, `{rd[15:0],rt[15:0]}`, `{rd[23:0],rt[7:0]}`, `rd`.
  - LWR, by `a` = 0/1/2/3: `rd`, `{rt[31:24],rd[31:8]}`, `{rt[31:16],rd[31:16]}`, `{rt[31:8],rd[31:24]}`.
- `MS_UNALIGNED_LOAD_EN` undefined: `ld_op` 6 and 7 behave as LW. `es_rt_value` is unused.

## Test plan
- **Non-load.** ADD enters with `alu_result=0x1234`, `ws_allowin=1`. Required: `ms_to_ws_valid=1` next cycle with `ms_final_result=0x1234`; `ms_fwd_stall` never high.
- **Byte loads, delayed response.** LB at `a=3` with `rdata=0x80FF_0000` and `data_ok` 3 cycles after entry. Required: result `0xFFFFFF80`; `ms_fwd_stall` high for 3 cycles. LBU with the same data gives `0x00000080`.
- **WB stall buffering.** LW gets `data_ok` with `rdata=0xDEADBEEF` while `ws_allowin=0` for 2 cycles. Required: the result is held from `rbuf`; `ms_to_ws_valid` stays high; the value is passed on the cycle `ws_allowin` rises.
- **Flush with outstanding responses.** Flush while MS is in `WAIT` and EX holds another request. Required: `cancel_cnt=2`; the next two `data_ok` are ignored; a following LW receives the third response.
- **Unaligned loads.** With the macro defined: LWL at `a=1`, `rt=0x11223344`, `rd=0xAABBCCDD` gives `0xCCDD3344`; LWR at `a=2` gives `0x1122AABB`. Without the macro, both give `0xAABBCCDD`.
- **Asynchronous reset.** `resetn` low mid-`WAIT`. Required: all outputs drop to their reset values immediately, without waiting for `clk`.

Source files
------------

// File: rtl/mem_stage_split_if.sv
// Bundle of EX->MS, data-SRAM response, MS->WB and forwarding signals around the MEM stage.
interface mem_stage_split_if;
    logic        es_to_ms_valid;
    logic        ms_allowin;
    logic [31:0] es_pc;
    logic [31:0] es_alu_result;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic [31:0] es_rt_value;
    logic [2:0]  es_ld_op;
    logic        es_mem_req;
    logic        flush;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [4:0]  ms_dest;
    logic        ms_gr_we;
    logic [31:0] ms_final_result;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;
    logic        ms_fwd_stall;

    modport master (
        output es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we, es_rt_value,
               es_ld_op, es_mem_req, flush, data_sram_data_ok, data_sram_rdata, ws_allowin,
        input  ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_gr_we, ms_final_result,
               ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_stall
    );

    modport slave (
        input  es_to_ms_valid, es_pc, es_alu_result, es_dest, es_gr_we, es_rt_value,
               es_ld_op, es_mem_req, flush, data_sram_data_ok, data_sram_rdata, ws_allowin,
        output ms_allowin, ms_to_ws_valid, ms_pc, ms_dest, ms_gr_we, ms_final_result,
               ms_fwd_valid, ms_fwd_dest, ms_fwd_data, ms_fwd_stall
    );
endinterface

// File: rtl/mem_stage_split.sv
// MEM stage for a split-transaction data SRAM: buffers early responses, discards flushed ones.
// Define MS_UNALIGNED_LOAD_EN to enable the LWL/LWR merge; otherwise those ops behave as LW.
module mem_stage_split #(
    parameter int CANCEL_W = 2
) (
    input logic             clk,
    input logic             resetn,
    mem_stage_split_if.slave bus
);
    typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_READY} state_e;

    localparam logic [CANCEL_W-1:0] CNT_MAX = '1;
    localparam logic [CANCEL_W-1:0] CNT_ONE = CANCEL_W'(1);

    state_e              state_q, state_d;
    logic [CANCEL_W-1:0] cancel_q, cancel_d;
    logic [31:0]         pc_q, alu_q, rbuf_q;
    logic [4:0]          dest_q;
    logic                gr_we_q;
    logic [2:0]          ld_op_q;
`ifdef MS_UNALIGNED_LOAD_EN
    logic [31:0]         rt_q;
`endif

    logic        in_wait, ms_valid, usable_ok, ready_go, allowin, accept, to_ws;
    logic [31:0] load_src, result;

`ifdef MS_UNALIGNED_LOAD_EN
    function automatic logic [31:0] load_align(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] rd, input logic [31:0] rt);
`else
    function automatic logic [31:0] load_align(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] rd);
`endif
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = a[1] ? rd[31:16] : rd[15:0];
        b = rd[{a, 3'b000} +: 8];
        r = rd;
        case (op)
            3'd2: r = {{16{h[15]}}, h};
            3'd3: r = {16'h0000, h};
            3'd4: r = {{24{b[7]}}, b};
            3'd5: r = {24'h000000, b};
`ifdef MS_UNALIGNED_LOAD_EN
            3'd6: begin
                case (a)
                    2'd0:    r = {rd[7:0],  rt[23:0]};
                    2'd1:    r = {rd[15:0], rt[15:0]};
                    2'd2:    r = {rd[23:0], rt[7:0]};
                    default: r = rd;
                endcase
            end
            3'd7: begin
                case (a)
                    2'd0:    r = rd;
                    2'd1:    r = {rt[31:24], rd[31:8]};
                    2'd2:    r = {rt[31:16], rd[31:16]};
                    default: r = {rt[31:8],  rd[31:24]};
                endcase
            end
`endif
            default: r = rd;
        endcase
        return r;
    endfunction

    // A response only belongs to the resident load once every flushed response has drained.
    assign usable_ok = bus.data_sram_data_ok & (cancel_q == '0);
    assign in_wait   = (state_q == S_WAIT);
    assign ms_valid  = (state_q != S_EMPTY);
    assign ready_go  = (state_q == S_READY) | (in_wait & usable_ok);
    assign allowin   = (~ms_valid | (ready_go & bus.ws_allowin)) & (cancel_q != CNT_MAX);
    assign accept    = bus.es_to_ms_valid & allowin & ~bus.flush;
    assign to_ws     = ready_go & ~bus.flush;

    assign load_src = in_wait ? bus.data_sram_rdata : rbuf_q;
`ifdef MS_UNALIGNED_LOAD_EN
    assign result = (ld_op_q == 3'd0) ? alu_q : load_align(ld_op_q, alu_q[1:0], load_src, rt_q);
`else
    assign result = (ld_op_q == 3'd0) ? alu_q : load_align(ld_op_q, alu_q[1:0], load_src);
`endif

    assign bus.ms_allowin      = allowin;
    assign bus.ms_to_ws_valid  = to_ws;
    assign bus.ms_pc           = pc_q;
    assign bus.ms_dest         = dest_q;
    assign bus.ms_gr_we        = to_ws & gr_we_q;
    assign bus.ms_final_result = result;
    assign bus.ms_fwd_valid    = ms_valid & gr_we_q;
    assign bus.ms_fwd_dest     = dest_q;
    assign bus.ms_fwd_data     = result;
    assign bus.ms_fwd_stall    = in_wait & ~usable_ok;

    always_comb begin
        state_d  = state_q;
        cancel_d = cancel_q;
        if (bus.flush) begin
            state_d = S_EMPTY;
        end else if (accept) begin
            state_d = bus.es_mem_req ? S_WAIT : S_READY;
        end else if (ready_go & bus.ws_allowin) begin
            state_d = S_EMPTY;
        end else if (in_wait & usable_ok) begin
            state_d = S_READY;
        end
        // Every request killed by a flush still owes one response that must be swallowed.
        if (bus.flush & in_wait & ~usable_ok) begin
            cancel_d = cancel_d + CNT_ONE;
        end
        if (bus.flush & bus.es_to_ms_valid & bus.es_mem_req) begin
            cancel_d = cancel_d + CNT_ONE;
        end
        if (bus.data_sram_data_ok & (cancel_q != '0)) begin
            cancel_d = cancel_d - CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_EMPTY;
            cancel_q <= '0;
        end else begin
            state_q  <= state_d;
            cancel_q <= cancel_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= '0;
            alu_q   <= '0;
            dest_q  <= '0;
            gr_we_q <= 1'b0;
            ld_op_q <= '0;
            rbuf_q  <= '0;
`ifdef MS_UNALIGNED_LOAD_EN
            rt_q    <= '0;
`endif
        end else begin
            if (accept) begin
                pc_q    <= bus.es_pc;
                alu_q   <= bus.es_alu_result;
                dest_q  <= bus.es_dest;
                gr_we_q <= bus.es_gr_we;
                ld_op_q <= bus.es_ld_op;
`ifdef MS_UNALIGNED_LOAD_EN
                rt_q    <= bus.es_rt_value;
`endif
            end
            if (in_wait & usable_ok) begin
                rbuf_q <= bus.data_sram_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage_split.sv
// Directed bench for mem_stage_split: a per-cycle response-queue model plus literal spot checks.
module tb_mem_stage_split;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mem_stage_split_if bus();

    mem_stage_split #(.CANCEL_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Load result derived from the ISA rules using shifts and masks.
    function automatic logic [31:0] spec_result(input logic [2:0] op, input logic [31:0] alu,
                                                input logic [31:0] rd, input logic [31:0] rt);
        int          sh;
        logic [31:0] t;
        sh = 8 * int'(alu[1:0]);
        t  = rd;
        case (op)
            3'd0: t = alu;
            3'd2: begin t = (rd >> (alu[1] ? 16 : 0)) & 32'h0000FFFF; if (t[15]) t = t | 32'hFFFF0000; end
            3'd3: t = (rd >> (alu[1] ? 16 : 0)) & 32'h0000FFFF;
            3'd4: begin t = (rd >> sh) & 32'h000000FF; if (t[7]) t = t | 32'hFFFFFF00; end
            3'd5: t = (rd >> sh) & 32'h000000FF;
`ifdef MS_UNALIGNED_LOAD_EN
            3'd6: t = (rd << (24 - sh)) | (rt & (32'hFFFFFFFF >> (sh + 8)));
            3'd7: t = (rd >> sh) | (rt & ~(32'hFFFFFFFF >> sh));
`endif
            default: t = rd;
        endcase
        return t;
    endfunction

    // Model: one optional occupant plus an ordered list of owed responses (1 = live, 0 = flushed).
    bit          occ_v, occ_wait, occ_we;
    logic [31:0] occ_pc, occ_alu, occ_rt, occ_res;
    logic [4:0]  occ_dest;
    logic [2:0]  occ_op;
    bit          resp_q[$];

    always @(negedge clk) begin
        bit          ok_live, ready, allow, tows;
        int          ndis;
        logic [31:0] res;
        if (!resetn) begin
            occ_v = 0; occ_wait = 0; resp_q.delete();
            check("rst_to_ws", {31'b0, bus.ms_to_ws_valid}, 32'd0);
            check("rst_allowin", {31'b0, bus.ms_allowin}, 32'd1);
            check("rst_stall", {31'b0, bus.ms_fwd_stall}, 32'd0);
            check("rst_result", bus.ms_final_result, 32'd0);
        end else begin
            ok_live = bus.data_sram_data_ok && resp_q.size() > 0 && resp_q[0];
            ndis = 0;
            foreach (resp_q[i]) if (!resp_q[i]) ndis++;
            ready = occ_v && (!occ_wait || ok_live);
            allow = (!occ_v || (ready && bus.ws_allowin)) && ndis != 3;
            tows  = ready && !bus.flush;
            res   = occ_wait ? spec_result(occ_op, occ_alu, bus.data_sram_rdata, occ_rt) : occ_res;
            check("m_to_ws", {31'b0, bus.ms_to_ws_valid}, {31'b0, tows});
            check("m_allowin", {31'b0, bus.ms_allowin}, {31'b0, allow});
            check("m_stall", {31'b0, bus.ms_fwd_stall}, {31'b0, occ_v && occ_wait && !ok_live});
            check("m_fwd_valid", {31'b0, bus.ms_fwd_valid}, {31'b0, occ_v && occ_we});
            check("m_gr_we", {31'b0, bus.ms_gr_we}, {31'b0, tows && occ_we});
            if (tows) begin
                check("m_pc", bus.ms_pc, occ_pc);
                check("m_dest", {27'b0, bus.ms_dest}, {27'b0, occ_dest});
                check("m_result", bus.ms_final_result, res);
                check("m_fwd_dest", {27'b0, bus.ms_fwd_dest}, {27'b0, occ_dest});
                check("m_fwd_data", bus.ms_fwd_data, res);
            end
            if (bus.data_sram_data_ok && resp_q.size() > 0) begin
                void'(resp_q.pop_front());
                if (ok_live) begin occ_res = res; occ_wait = 0; end
            end
            if (bus.flush) begin
                foreach (resp_q[i]) resp_q[i] = 0;
                if (bus.es_to_ms_valid && bus.es_mem_req) resp_q.push_back(0);
                occ_v = 0;
            end else if (bus.es_to_ms_valid && allow) begin
                occ_v = 1; occ_wait = bus.es_mem_req; occ_we = bus.es_gr_we;
                occ_pc = bus.es_pc; occ_alu = bus.es_alu_result; occ_rt = bus.es_rt_value;
                occ_dest = bus.es_dest; occ_op = bus.es_ld_op; occ_res = bus.es_alu_result;
                if (bus.es_mem_req) resp_q.push_back(1);
            end else if (ready && bus.ws_allowin) begin
                occ_v = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.es_to_ms_valid    = 1'b0;
        bus.es_mem_req        = 1'b0;
        bus.flush             = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'h0;
        bus.ws_allowin        = 1'b1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] alu, input logic [4:0] dest,
                         input logic [2:0] op, input logic req, input logic [31:0] rt);
        bus.es_to_ms_valid = 1'b1;
        bus.es_pc          = pc;
        bus.es_alu_result  = alu;
        bus.es_dest        = dest;
        bus.es_gr_we       = 1'b1;
        bus.es_ld_op       = op;
        bus.es_mem_req     = req;
        bus.es_rt_value    = rt;
    endtask

    task automatic respond(input logic [31:0] rd);
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = rd;
    endtask

    // Issue a load, then return rd on its first MS cycle and check the written-back value.
    task automatic load_once(input string name, input logic [2:0] op, input logic [31:0] alu,
                             input logic [31:0] rt, input logic [31:0] rd, input logic [31:0] req);
        issue(32'h400, alu, 5'd9, op, 1'b1, rt);
        tick(); idle(); respond(rd); #1;
        check(name, bus.ms_final_result, req);
        tick(); idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        issue(32'h0, 32'h0, 5'd0, 3'd0, 1'b0, 32'h0);
        bus.es_to_ms_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Non-load
        issue(32'h100, 32'h1234, 5'd3, 3'd0, 1'b0, 32'h0);
        tick(); idle(); #1;
        check("add_valid", {31'b0, bus.ms_to_ws_valid}, 32'd1);
        check("add_result", bus.ms_final_result, 32'h1234);
        check("add_stall", {31'b0, bus.ms_fwd_stall}, 32'd0);
        tick();

        // LB / LBU with a three-cycle response delay
        for (int k = 0; k < 2; k++) begin
            issue(32'h104, 32'h1003, 5'd4, (k == 0) ? 3'd4 : 3'd5, 1'b1, 32'h0);
            tick(); idle();
            for (int c = 0; c < 3; c++) begin
                #1 check("lb_stall", {31'b0, bus.ms_fwd_stall}, 32'd1);
                tick();
            end
            respond(32'h80FF_0000); #1;
            check("lb_stall_off", {31'b0, bus.ms_fwd_stall}, 32'd0);
            check("lb_result", bus.ms_final_result, (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080);
            tick(); idle();
        end

        // WB stall buffering
        issue(32'h108, 32'h2000, 5'd5, 3'd1, 1'b1, 32'h0);
        tick(); idle(); respond(32'hDEAD_BEEF); bus.ws_allowin = 1'b0; #1;
        check("buf_first", bus.ms_final_result, 32'hDEAD_BEEF);
        tick(); idle(); bus.ws_allowin = 1'b0; #1;
        check("buf_valid", {31'b0, bus.ms_to_ws_valid}, 32'd1);
        check("buf_hold", bus.ms_final_result, 32'hDEAD_BEEF);
        check("buf_allowin", {31'b0, bus.ms_allowin}, 32'd0);
        tick(); idle(); #1;
        check("buf_pass", bus.ms_final_result, 32'hDEAD_BEEF);
        check("buf_allowin_up", {31'b0, bus.ms_allowin}, 32'd1);
        tick();

        // Flush with MS waiting and EX requesting: two discards, third response is live
        issue(32'h200, 32'h3000, 5'd6, 3'd1, 1'b1, 32'h0);
        tick(); idle();
        issue(32'h204, 32'h3004, 5'd7, 3'd1, 1'b1, 32'h0); bus.flush = 1'b1;
        tick(); idle(); #1;
        check("fl_allowin", {31'b0, bus.ms_allowin}, 32'd1);
        issue(32'h208, 32'h3008, 5'd8, 3'd1, 1'b1, 32'h0);
        tick(); idle(); respond(32'h1111_1111); #1;
        check("fl_discard1", {31'b0, bus.ms_to_ws_valid}, 32'd0);
        tick(); idle(); respond(32'h2222_2222); #1;
        check("fl_discard2", {31'b0, bus.ms_fwd_stall}, 32'd1);
        tick(); idle(); respond(32'h3333_3333); #1;
        check("fl_live", bus.ms_final_result, 32'h3333_3333);
        tick(); idle();

        // Saturated discard counter blocks entry until a discard
        issue(32'h300, 32'h4000, 5'd1, 3'd1, 1'b1, 32'h0);
        tick(); idle();
        issue(32'h304, 32'h4004, 5'd1, 3'd1, 1'b1, 32'h0); bus.flush = 1'b1;
        tick(); idle();
        issue(32'h308, 32'h4008, 5'd1, 3'd1, 1'b1, 32'h0); bus.flush = 1'b1;
        tick(); idle(); #1;
        check("sat_block", {31'b0, bus.ms_allowin}, 32'd0);
        tick(); idle(); respond(32'h5); #1;
        check("sat_block_dis", {31'b0, bus.ms_allowin}, 32'd0);
        tick(); idle(); #1;
        check("sat_release", {31'b0, bus.ms_allowin}, 32'd1);
        respond(32'h6); tick(); idle(); respond(32'h7); tick(); idle();

        // Halfword and unaligned loads
        load_once("lh", 3'd2, 32'h2, 32'h0, 32'h8001_7FFF, 32'hFFFF_8001);
        load_once("lhu", 3'd3, 32'h0, 32'h0, 32'h8001_7FFF, 32'h0000_7FFF);
`ifdef MS_UNALIGNED_LOAD_EN
        load_once("lwl", 3'd6, 32'h1, 32'h1122_3344, 32'hAABB_CCDD, 32'hCCDD_3344);
        load_once("lwr", 3'd7, 32'h2, 32'h1122_3344, 32'hAABB_CCDD, 32'h1122_AABB);
`else
        load_once("lwl", 3'd6, 32'h1, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
        load_once("lwr", 3'd7, 32'h2, 32'h1122_3344, 32'hAABB_CCDD, 32'hAABB_CCDD);
`endif

        // Asynchronous reset while waiting
        issue(32'h500, 32'h6000, 5'd2, 3'd1, 1'b1, 32'h0);
        tick(); idle(); #1;
        check("ar_pre_stall", {31'b0, bus.ms_fwd_stall}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("ar_stall", {31'b0, bus.ms_fwd_stall}, 32'd0);
        check("ar_allowin", {31'b0, bus.ms_allowin}, 32'd1);
        check("ar_pc", bus.ms_pc, 32'd0);
        check("ar_dest", {27'b0, bus.ms_dest}, 32'd0);
        check("ar_fwd_valid", {31'b0, bus.ms_fwd_valid}, 32'd0);
        tick(); resetn = 1'b1;
        issue(32'h600, 32'h7777, 5'd3, 3'd0, 1'b0, 32'h0);
        tick(); idle(); #1;
        check("post_rst", bus.ms_final_result, 32'h7777);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
